// File: rtl/pio_debounce_edge_in_if.sv
// Avalon-MM slave bus for the debounced input PIO: register access plus interrupt.
// A write completes on the clk edge where chipselect=1 and write_n=0; reads return readdata one clk after address.
interface pio_debounce_edge_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_debounce_edge_in.sv
// Input PIO with synchronisers, tick-based per-channel debounce, rise/fall edge capture and a level irq.
module pio_debounce_edge_in #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 1000,
    parameter int DB_RESET    = 8,
    parameter int EDGE_W1C    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_debounce_edge_in_if.slave bus,
    input  logic [WIDTH-1:0]     in_port
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] raw;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [7:0]       db_cnt [WIDTH];
    logic [WIDTH-1:0] deb, deb_d;
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, cap;
    logic [WIDTH-1:0] edge_hit, cap_clr, cap_next, wdata_w;
    logic [7:0]       db_len;
    logic [31:0]      rd_mux;
    logic             wr;

    assign raw     = sync_q[SYNC_STAGES-1];
    assign tick    = (pre_cnt == PW'(PRESCALE - 1));
    assign wr      = bus.chipselect & ~bus.write_n;
    assign wdata_w = bus.writedata[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            pre_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end

    // A zero debounce length bypasses the counters so deb tracks raw every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
            deb   <= '0;
            deb_d <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (db_len == 8'd0) begin
                    deb[i]    <= raw[i];
                    db_cnt[i] <= '0;
                end else if (raw[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (9'(db_cnt[i]) + 9'd1 >= 9'(db_len)) begin
                        deb[i]    <= raw[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign edge_hit = (deb & ~deb_d & rise_en) | (~deb & deb_d & fall_en);

    // W1C lets a coincident edge survive its own clear; the legacy mode clears unconditionally.
    always_comb begin
        cap_clr = '0;
        if (wr && bus.address == 3'd3) cap_clr = (EDGE_W1C != 0) ? wdata_w : '1;
        if (EDGE_W1C != 0) cap_next = (cap & ~cap_clr) | edge_hit;
        else               cap_next = (cap | edge_hit) & ~cap_clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '0;
            irq_mask <= '0;
            fall_en  <= '1;
            db_len   <= 8'(DB_RESET);
            cap      <= '0;
        end else begin
            cap <= cap_next;
            if (wr) begin
                case (bus.address)
                    3'd1:    rise_en  <= wdata_w;
                    3'd2:    irq_mask <= wdata_w;
                    3'd4:    fall_en  <= wdata_w;
                    3'd5:    db_len   <= bus.writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = 32'(deb);
            3'd1:    rd_mux = 32'(rise_en);
            3'd2:    rd_mux = 32'(irq_mask);
            3'd3:    rd_mux = 32'(cap);
            3'd4:    rd_mux = 32'(fall_en);
            3'd5:    rd_mux = {24'd0, db_len};
            3'd6:    rd_mux = 32'(raw);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign bus.irq = |(cap & irq_mask);
endmodule

// File: tb/tb_pio_debounce_edge_in.sv
// Directed bench for pio_debounce_edge_in: a W1C instance and a legacy-clear instance share one bus and inputs.
module tb_pio_debounce_edge_in;
    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic       req, req_q;
    int         n_vec, n_err;

    // {sel, expected}: sel 0 = readdata0, 1 = irq0, 2 = readdata1, 3 = irq1
    logic [33:0] exp_q[$];
    string       name_q[$];

    pio_debounce_edge_in_if bus0 ();
    pio_debounce_edge_in_if bus1 ();

    assign bus1.address    = bus0.address;
    assign bus1.chipselect = bus0.chipselect;
    assign bus1.write_n    = bus0.write_n;
    assign bus1.writedata  = bus0.writedata;

    pio_debounce_edge_in #(.WIDTH(4), .SYNC_STAGES(2), .PRESCALE(4), .DB_RESET(8), .EDGE_W1C(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port)
    );
    pio_debounce_edge_in #(.WIDTH(4), .SYNC_STAGES(2), .PRESCALE(4), .DB_RESET(8), .EDGE_W1C(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard compare
    function automatic void chk(input logic [1:0] sel, input logic [31:0] e, input string nm);
        logic [31:0] a;
        case (sel)
            2'd0:    a = bus0.readdata;
            2'd1:    a = {31'd0, bus0.irq};
            2'd2:    a = bus1.readdata;
            default: a = {31'd0, bus1.irq};
        endcase
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endfunction

    // monitor: responses appear one clk after the request cycle
    always @(posedge clk) req_q <= req;
    always @(negedge clk) begin
        if (req_q) begin
            while (exp_q.size() > 0) begin
                logic [33:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(e[33:32], e[31:0], nm);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
        bus0.chipselect = 1'b0;
        bus0.write_n    = 1'b1;
        req             = 1'b0;
    endtask

    task automatic expect_(input logic [1:0] sel, input logic [31:0] e, input string nm);
        exp_q.push_back({sel, e});
        name_q.push_back(nm);
        req = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step();
        bus0.address    = a;
        bus0.writedata  = d;
        bus0.chipselect = 1'b1;
        bus0.write_n    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        step();
        bus0.address = a;
        expect_(2'd0, e, nm);
    endtask

    task automatic wait_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        req = 1'b0; reset_n = 1'b0; in_port = 4'h0;
        bus0.address = 3'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;

        // reset values
        wait_steps(2);
        rd(3'd4, 32'h0, "rd_in_reset"); expect_(2'd1, 32'h0, "irq_in_reset");
        step(); reset_n = 1'b1;
        rd(3'd0, 32'h0, "rst_data");
        rd(3'd4, 32'hF, "rst_fall_en"); expect_(2'd2, 32'hF, "rst_fall_en_1");
        rd(3'd5, 32'h8, "rst_debounce");
        rd(3'd7, 32'h0, "rst_addr7");   expect_(2'd1, 32'h0, "rst_irq");

        // debounce 0 -> F with DEBOUNCE=3
        wr(3'd5, 32'h3);
        step(); in_port = 4'hF;
        rd(3'd6, 32'h0, "raw_before");
        rd(3'd6, 32'hF, "raw_after");
        wait_steps(7);
        rd(3'd0, 32'h0, "data_early");
        wait_steps(3);
        rd(3'd0, 32'hF, "data_settled");
        wait_steps(14);
        rd(3'd3, 32'h0, "cap_no_rise"); expect_(2'd2, 32'h0, "cap_no_rise_1");

        // glitch on bit1 is rejected, then a sustained low is accepted
        step(); in_port = 4'hD;
        wait_steps(4);
        step(); in_port = 4'hF;
        wait_steps(12);
        rd(3'd0, 32'hF, "glitch_data");
        rd(3'd3, 32'h0, "glitch_cap");
        step(); in_port = 4'hD;
        wait_steps(9);
        rd(3'd0, 32'hF, "hold_data_early");
        wait_steps(4);
        rd(3'd0, 32'hD, "hold_data");
        rd(3'd3, 32'h2, "fall1_cap"); expect_(2'd2, 32'h2, "fall1_cap_1");
        wr(3'd3, 32'h2);
        rd(3'd3, 32'h0, "fall1_clr"); expect_(2'd2, 32'h0, "fall1_clr_1");

        // masked falling edge on bit2 raises irq; W1C only clears the written bit
        wr(3'd2, 32'h4);
        step(); in_port = 4'h9;
        wait_steps(16);
        rd(3'd0, 32'h9, "fall2_data");
        rd(3'd3, 32'h4, "fall2_cap");
        expect_(2'd2, 32'h4, "fall2_cap_1");
        expect_(2'd1, 32'h1, "irq_set");
        expect_(2'd3, 32'h1, "irq_set_1");
        wr(3'd3, 32'h1); expect_(2'd1, 32'h1, "irq_other_clr"); expect_(2'd3, 32'h0, "irq_legacy_clr");
        rd(3'd3, 32'h4, "cap_other_clr"); expect_(2'd2, 32'h0, "cap_legacy_clr");
        wr(3'd3, 32'h4); expect_(2'd1, 32'h0, "irq_clr");
        rd(3'd3, 32'h0, "cap_clr");

        // clear coincident with a rising edge, bypass debounce for exact timing
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h0);
        wr(3'd1, 32'h1);
        step(); in_port = 4'h8;
        wait_steps(4);
        rd(3'd0, 32'h8, "bypass_fall_data");
        rd(3'd3, 32'h0, "no_fall_cap"); expect_(2'd2, 32'h0, "no_fall_cap_1");
        step(); in_port = 4'h9;
        wait_steps(2);
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h1, "w1c_set_wins"); expect_(2'd2, 32'h0, "legacy_clr_wins");
        rd(3'd0, 32'h9, "rise_data");

        // bypass latency is SYNC_STAGES+1 clks
        step(); in_port = 4'h1;
        step();
        rd(3'd0, 32'h9, "byp_fall_pre");
        rd(3'd0, 32'h1, "byp_fall_post");
        step(); in_port = 4'h9;
        step();
        rd(3'd0, 32'h1, "byp_rise_pre");
        rd(3'd0, 32'h9, "byp_rise_post");

        // asynchronous reset in the middle of a debounce count
        wr(3'd2, 32'h1); expect_(2'd1, 32'h1, "irq_pre_reset");
        wr(3'd5, 32'h3);
        step(); in_port = 4'h1;
        wait_steps(3);
        rd(3'd5, 32'h3, "db_pre_reset");
        step();
        #1 reset_n = 1'b0;
        #1;
        chk(2'd0, 32'h0, "async_rd");
        chk(2'd1, 32'h0, "async_irq");
        chk(2'd2, 32'h0, "async_rd_1");
        rd(3'd4, 32'h0, "rd_held_reset");
        step(); reset_n = 1'b1;
        rd(3'd4, 32'hF, "post_fall_en");
        rd(3'd5, 32'h8, "post_debounce");
        rd(3'd1, 32'h0, "post_rise_en");
        rd(3'd2, 32'h0, "post_mask");
        rd(3'd3, 32'h0, "post_cap"); expect_(2'd1, 32'h0, "post_irq");
        rd(3'd0, 32'h0, "post_data");
        rd(3'd6, 32'h1, "post_raw");
        wait_steps(3);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
